line_queue: RTL



---
 rtl/line_queue.sv | 138 +++++++++++++
 1 files changed

// File: rtl/line_queue.sv
`default_nettype none
// ============================================================================
//  Module   : line_queue
//  Purpose  : Buffers line commands and dispatches them one at a time to the
//             line drawer over a start/done handshake.
//  Revision : 1.0  initial release
// ============================================================================
module line_queue #(
    parameter int CORDW = 16,
    parameter int CIDXW = 4,
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic signed [CORDW-1:0]      x0,
    input  logic signed [CORDW-1:0]      y0,
    input  logic signed [CORDW-1:0]      x1,
    input  logic signed [CORDW-1:0]      y1,
    input  logic [CIDXW-1:0]             cidx,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         run,
    output logic signed [CORDW-1:0]      lx0,
    output logic signed [CORDW-1:0]      ly0,
    output logic signed [CORDW-1:0]      lx1,
    output logic signed [CORDW-1:0]      ly1,
    output logic [CIDXW-1:0]             lcidx,
    output logic                         draw_start,
    input  logic                         draw_done,
    output logic                         busy,
    output logic                         idle
);

    localparam int c_PTRW = $clog2(DEPTH);
    localparam int c_CNTW = $clog2(DEPTH+1);
    localparam int c_ENTW = 4*CORDW + CIDXW;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;

    logic [c_ENTW-1:0] r_mem [DEPTH];
    logic [c_PTRW-1:0] r_wr_ptr;
    logic [c_PTRW-1:0] r_rd_ptr;
    logic [c_CNTW-1:0] r_count;
    logic [c_CNTW-1:0] w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_overflow;
    logic              r_idle;
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              w_push_ok;
    logic              w_pop;
    logic signed [CORDW-1:0] r_lx0, r_ly0, r_lx1, r_ly1;
    logic [CIDXW-1:0]  r_lcidx;

    // A push into a full queue is dropped even if a pop frees a slot this cycle.
    always_comb begin
        w_push_ok   = push && !r_full;
        w_pop       = (r_state == c_S_IDLE) && run && !r_empty;
        w_count_nxt = r_count;
        case ({w_push_ok, w_pop})
            2'b10:   w_count_nxt = r_count + c_CNTW'(1);
            2'b01:   w_count_nxt = r_count - c_CNTW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_pop)     w_state_nxt = c_S_START;
            c_S_START:                w_state_nxt = c_S_WAIT;
            c_S_WAIT:  if (draw_done) w_state_nxt = c_S_IDLE;
            default:                  w_state_nxt = c_S_IDLE;
        endcase
    end

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {x0, y0, x1, y1, cidx};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_idle     <= 1'b1;
            r_state    <= c_S_IDLE;
            r_lx0      <= '0;
            r_ly0      <= '0;
            r_lx1      <= '0;
            r_ly1      <= '0;
            r_lcidx    <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTRW'(1);
            end
            if (push && r_full) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                {r_lx0, r_ly0, r_lx1, r_ly1, r_lcidx} <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + c_PTRW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_CNTW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_idle  <= (w_state_nxt == c_S_IDLE) && (w_count_nxt == '0);
            r_state <= w_state_nxt;
        end
    end

    assign full       = r_full;
    assign empty      = r_empty;
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign idle       = r_idle;
    assign lx0        = r_lx0;
    assign ly0        = r_ly0;
    assign lx1        = r_lx1;
    assign ly1        = r_ly1;
    assign lcidx      = r_lcidx;
    assign draw_start = (r_state == c_S_START);
    assign busy       = (r_state == c_S_START) || (r_state == c_S_WAIT);

endmodule
`default_nettype wire
